// File: rtl/sseg_scan_ctrl_if.sv
// rtl/sseg_scan_ctrl_if.sv - load/scan signal bundle for sseg_scan_ctrl; SSEG_SCAN_BRIGHT_EN adds BRIGHT
interface sseg_scan_ctrl_if;
  logic [27:0] DIG_IN;
  logic [3:0]  DP_IN;
  logic        LOAD;
  logic [3:0]  EN_MASK;
`ifdef SSEG_SCAN_BRIGHT_EN
  logic [3:0]  BRIGHT;
`endif
  logic [3:0]  Anode;
  logic [6:0]  SSEG_Data;
  logic        dp;
  logic        LOAD_ACK;
  logic        FRAME;

`ifdef SSEG_SCAN_BRIGHT_EN
  modport master (output DIG_IN, DP_IN, LOAD, EN_MASK, BRIGHT,
                  input  Anode, SSEG_Data, dp, LOAD_ACK, FRAME);
  modport slave  (input  DIG_IN, DP_IN, LOAD, EN_MASK, BRIGHT,
                  output Anode, SSEG_Data, dp, LOAD_ACK, FRAME);
`else
  modport master (output DIG_IN, DP_IN, LOAD, EN_MASK,
                  input  Anode, SSEG_Data, dp, LOAD_ACK, FRAME);
  modport slave  (input  DIG_IN, DP_IN, LOAD, EN_MASK,
                  output Anode, SSEG_Data, dp, LOAD_ACK, FRAME);
`endif
endinterface

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - four-digit seven-segment scan controller with frame-aligned double buffer
// SSEG_SCAN_BRIGHT_EN defined: BRIGHT[3:0] sets the lit fraction of each SHOW phase.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic            CLK,
  input  logic            RST_N,
  sseg_scan_ctrl_if.slave bus
);
  localparam int MAXC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [27:0]   r_active;
  logic [3:0]    r_active_dp;
  logic [27:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  logic          r_pending;
  logic [3:0]    r_anode;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_load_ack;
  logic          r_frame;

  logic [1:0]    w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [1:0]    w_nxt_idx;
  logic          w_boundary;
  logic [1:0]    w_sel;
  logic [1:0]    w_low;
  logic [6:0]    w_digit;
  logic          w_lit;

  // First enabled index at or cyclically after start; returns start when none is enabled.
  function automatic logic [1:0] f_next_en(input logic [1:0] start, input logic [3:0] mask);
    logic [1:0] sel;
    sel = start;
    for (int k = 3; k >= 0; k--) begin
      if (mask[start + 2'(k)]) sel = start + 2'(k);
    end
    return sel;
  endfunction

  assign w_sel = f_next_en(r_idx + 2'd1, bus.EN_MASK);
  assign w_low = f_next_en(2'd0, bus.EN_MASK);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    w_nxt_idx   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        if (bus.EN_MASK != 4'h0) begin
          w_nxt_state = S_BLANK;
          w_nxt_idx   = w_low;
          w_boundary  = 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_nxt_state = S_SHOW;
          w_nxt_cnt   = '0;
        end
      end
      S_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_nxt_cnt = '0;
          if (bus.EN_MASK == 4'h0) begin
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = S_BLANK;
            w_nxt_idx   = w_sel;
            w_boundary  = (w_sel <= r_idx);
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  assign w_digit = 7'(r_active >> (7 * int'(w_nxt_idx)));

`ifdef SSEG_SCAN_BRIGHT_EN
  assign w_lit = (32'(w_nxt_cnt) * 32'd16) < ((32'(bus.BRIGHT) + 32'd1) * 32'(REFRESH_DIV));
`else
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_active    <= '0;
      r_active_dp <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_pending   <= 1'b0;
      r_anode     <= 4'hF;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
      r_load_ack  <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_idx      <= w_nxt_idx;
      r_frame    <= w_boundary;
      r_load_ack <= w_boundary & r_pending;
      if (w_boundary && r_pending) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
      end
      // A LOAD landing on a boundary edge keeps pending set for the following frame.
      if (bus.LOAD) begin
        r_shadow    <= bus.DIG_IN;
        r_shadow_dp <= bus.DP_IN;
        r_pending   <= 1'b1;
      end else if (w_boundary) begin
        r_pending   <= 1'b0;
      end
      if (w_nxt_state == S_SHOW) begin
        r_anode <= ~(4'b0001 << w_nxt_idx);
        r_seg   <= w_lit ? ~w_digit : 7'h7F;
        r_dp    <= w_lit ? ~r_active_dp[w_nxt_idx] : 1'b1;
      end else begin
        r_anode <= 4'hF;
        r_seg   <= 7'h7F;
        r_dp    <= 1'b1;
      end
    end
  end

  assign bus.Anode     = r_anode;
  assign bus.SSEG_Data = r_seg;
  assign bus.dp        = r_dp;
  assign bus.LOAD_ACK  = r_load_ack;
  assign bus.FRAME     = r_frame;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - scoreboard bench for sseg_scan_ctrl at REFRESH_DIV=4, BLANK_CYC=2
`timescale 1ns/1ps
module tb_sseg_scan_ctrl;
  localparam int RD = 4;
  localparam int BC = 2;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  sseg_scan_ctrl_if bus ();
  sseg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; int len; int blank; } dig_t;
  typedef struct { logic ack; int gap; } frm_t;

  dig_t dig_q[$];
  frm_t frm_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  logic [27:0] m_act, m_sh;
  logic [3:0]  m_act_dp, m_sh_dp;
  logic        m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one digit event per completed SHOW, one frame event per FRAME pulse.
  int         gap, blank_cnt, show_cnt, cur_blank;
  bit         in_show, stable, have_frame;
  logic [3:0] cur_an;
  logic [6:0] cur_seg;
  logic       cur_dp;
  frm_t       fe;
  dig_t       de;

  always @(negedge CLK) begin
    if (!mon_en) begin
      in_show = 0; blank_cnt = 0; show_cnt = 0; gap = 0; have_frame = 0;
    end else begin
      gap++;
      if (bus.FRAME === 1'b1) begin
        if (frm_q.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
        else begin
          fe = frm_q.pop_front();
          chk("frame_ack", bus.LOAD_ACK, fe.ack);
          if (fe.gap != 0 && have_frame) chk("frame_period", gap, fe.gap);
        end
        have_frame = 1; gap = 0;
      end else if (bus.LOAD_ACK !== 1'b0) begin
        chk("ack_outside_frame", bus.LOAD_ACK, 32'd0);
      end
      if (bus.Anode !== 4'hF) begin
        if (!in_show) begin
          in_show = 1; cur_an = bus.Anode; cur_seg = bus.SSEG_Data; cur_dp = bus.dp;
          show_cnt = 1; cur_blank = blank_cnt; stable = 1;
        end else begin
          show_cnt++;
          if (bus.Anode !== cur_an || bus.SSEG_Data !== cur_seg || bus.dp !== cur_dp) stable = 0;
        end
      end else begin
        chk("blank_seg_dp", {bus.SSEG_Data, bus.dp}, {7'h7F, 1'b1});
        if (in_show) begin
          in_show = 0;
          if (dig_q.size() == 0) chk("digit_unexpected", cur_an, 32'hF);
          else begin
            de = dig_q.pop_front();
            chk("anode", cur_an, de.an);
            chk("sseg", cur_seg, de.seg);
            chk("dp", cur_dp, de.dp);
            chk("show_len", show_cnt, de.len);
            if (de.blank != 0) chk("blank_len", cur_blank, de.blank);
            chk("show_stable", stable, 32'd1);
          end
          blank_cnt = 0;
        end
        blank_cnt++;
      end
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while (bus.FRAME !== 1'b1 && n < 200);
    if (bus.FRAME !== 1'b1) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // Applies the model commit for a boundary and queues that frame's expected digits.
  task automatic push_frame(input logic [3:0] mask, input int gp, input bit first);
    frm_t f;
    dig_t d;
    bit   lead;
    f.ack = m_pend;
    f.gap = gp;
    if (m_pend) begin
      m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
    end
    frm_q.push_back(f);
    lead = first;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        d.an    = ~(4'b0001 << i);
        d.seg   = ~m_act[7*i +: 7];
        d.dp    = ~m_act_dp[i];
        d.len   = RD;
        d.blank = lead ? 0 : BC;
        lead    = 1'b0;
        dig_q.push_back(d);
      end
    end
  endtask

  task automatic frame_step(input logic [3:0] mask, input int gp, input bit first);
    wait_frame();
    push_frame(mask, gp, first);
  endtask

  task automatic do_load(input logic [27:0] dig, input logic [3:0] dpv);
    bus.DIG_IN = dig; bus.DP_IN = dpv; bus.LOAD = 1'b1;
    @(posedge CLK); #1;
    bus.LOAD = 1'b0;
    m_sh = dig; m_sh_dp = dpv; m_pend = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_anode", bus.Anode, 32'hF);
    chk("rst_sseg", bus.SSEG_Data, 32'h7F);
    chk("rst_dp", bus.dp, 32'd1);
    chk("rst_load_ack", bus.LOAD_ACK, 32'd0);
    chk("rst_frame", bus.FRAME, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.EN_MASK = 4'hF; bus.LOAD = 1'b0; bus.DIG_IN = '0; bus.DP_IN = '0;
`ifdef SSEG_SCAN_BRIGHT_EN
    bus.BRIGHT = 4'hF;
`endif
    m_act = '0; m_sh = '0; m_act_dp = '0; m_sh_dp = '0; m_pend = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk_reset_outputs();
    mon_en = 1'b1; RST_N = 1'b1;

    // Free-running scan, blank data
    frame_step(4'hF, 0, 1'b1);
    frame_step(4'hF, 24, 1'b0);

    // Mid-frame load commits at the next frame
    repeat (5) @(posedge CLK); #1;
    do_load({21'h0, 7'h06}, 4'h1);
    frame_step(4'hF, 24, 1'b0);

    // Two loads in one frame: last wins, single ack
    repeat (3) @(posedge CLK); #1;
    do_load({21'h0, 7'h3F}, 4'h0);
    repeat (4) @(posedge CLK); #1;
    do_load({21'h0, 7'h5B}, 4'h0);
    frame_step(4'hF, 24, 1'b0);
    frame_step(4'hF, 24, 1'b0);

    // Sparse mask, then mask cleared mid-SHOW
    wait_frame();
    bus.EN_MASK = 4'b0101;
    push_frame(4'b0101, 24, 1'b0);
    frame_step(4'b0101, 12, 1'b0);
    wait_frame();
    push_frame(4'b0001, 12, 1'b0);
    repeat (3) @(posedge CLK); #1;
    bus.EN_MASK = 4'h0;
    repeat (20) @(posedge CLK); #1;
    chk("idle_anode", bus.Anode, 32'hF);
    chk("idle_frame", bus.FRAME, 32'd0);

    // Load held in IDLE until the scan resumes
    do_load({14'h0, 7'h5B, 7'h00}, 4'h2);
    repeat (3) @(posedge CLK); #1;
    bus.EN_MASK = 4'hF;
    frame_step(4'hF, 0, 1'b1);

    // Load landing on the boundary cycle while pending
    do_load({21'h0, 7'h66}, 4'h0);
    repeat (22) @(posedge CLK); #1;
    bus.DIG_IN = {21'h0, 7'h4F}; bus.DP_IN = 4'h8; bus.LOAD = 1'b1;
    @(posedge CLK); #1;
    bus.LOAD = 1'b0;
    push_frame(4'hF, 24, 1'b0);
    m_sh = {21'h0, 7'h4F}; m_sh_dp = 4'h8; m_pend = 1'b1;
    frame_step(4'hF, 24, 1'b0);

    // Reset mid-SHOW discards uncommitted data
    frame_step(4'hF, 24, 1'b0);
    do_load({21'h0, 7'h7D}, 4'hF);
    repeat (2) @(posedge CLK); #1;
    chk("pre_rst_anode", bus.Anode, 32'hE);
    chk("pre_rst_sseg", bus.SSEG_Data, 32'h30);
    mon_en = 1'b0;
    dig_q.delete(); frm_q.delete();
    RST_N = 1'b0;
    #1;
    chk_reset_outputs();
    m_act = '0; m_sh = '0; m_act_dp = '0; m_sh_dp = '0; m_pend = 1'b0;
    repeat (2) @(posedge CLK); #1;
    mon_en = 1'b1; RST_N = 1'b1;
    frame_step(4'hF, 0, 1'b1);

    wait_frame();
    push_frame(4'b0001, 24, 1'b0);
    bus.EN_MASK = 4'h0;
    repeat (20) @(posedge CLK); #1;
    chk("digit_queue_drained", dig_q.size(), 32'd0);
    chk("frame_queue_drained", frm_q.size(), 32'd0);
    chk("final_idle_anode", bus.Anode, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
